// File: rtl/vliw_hazard_pkg.sv
// vliw_hazard_pkg: shared FSM states, forwarding-select codes and helpers for the VLIW hazard controller.
package vliw_hazard_pkg;

    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_P3_ALU  = 2'd1;
    localparam logic [1:0] FWD_P4_ALU  = 2'd2;
    localparam logic [1:0] FWD_P4_MEM  = 2'd3;

    localparam int MEM_TIMEOUT_DEF = 15;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && !(&v)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/vliw_fwd_sel.sv
// vliw_fwd_sel: priority compare of one decode-stage source against the in-flight destinations.
module vliw_fwd_sel
    import vliw_hazard_pkg::*;
#(
    parameter int NREG_BITS = 3
) (
    input  logic [NREG_BITS-1:0] rs,
    input  logic                 use_rs,
    input  logic [NREG_BITS-1:0] p2_alu_rd,
    input  logic                 p2_alu_we,
    input  logic [NREG_BITS-1:0] p2_mem_rd,
    input  logic                 p2_mem_we,
    input  logic [NREG_BITS-1:0] p3_alu_rd,
    input  logic                 p3_alu_we,
    input  logic [NREG_BITS-1:0] p3_mem_rd,
    input  logic                 p3_mem_we,
    output logic [1:0]           sel,
    output logic                 p2_load_hit
);
    logic h2a, h2m, h3a, h3m;

    assign h2a = use_rs & p2_alu_we & (p2_alu_rd == rs);
    assign h2m = use_rs & p2_mem_we & (p2_mem_rd == rs);
    assign h3a = use_rs & p3_alu_we & (p3_alu_rd == rs);
    assign h3m = use_rs & p3_mem_we & (p3_mem_rd == rs);
    assign p2_load_hit = h2m;

    // Younger stage wins; within a stage the MEM slot wins. A p2 load cannot forward (stall instead).
    assign sel = h2m ? FWD_REGFILE :
                 h2a ? FWD_P3_ALU  :
                 h3m ? FWD_P4_MEM  :
                 h3a ? FWD_P4_ALU  : FWD_REGFILE;

endmodule

// File: rtl/vliw_hazard_ctrl.sv
// vliw_hazard_ctrl: forwarding selects, load-use/store stalls, dmem wait and branch flush control.
// Optional perf counters (stall_load_cnt, stall_mem_cnt, flush_cnt, clear_cnt) under HAZARD_PERF_CNT_EN.
module vliw_hazard_ctrl
    import vliw_hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int NREG_BITS   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREG_BITS-1:0] p1_alu_rn,
    input  logic [NREG_BITS-1:0] p1_alu_rm,
    input  logic [NREG_BITS-1:0] p1_mem_rn,
    input  logic [NREG_BITS-1:0] p1_mem_rd,
    input  logic                 p1_alu_useRm,
    input  logic                 p1_memWrite,
    input  logic                 p1_valid,
    input  logic [NREG_BITS-1:0] p2_alu_rd,
    input  logic [NREG_BITS-1:0] p2_mem_rd,
    input  logic                 p2_alu_regWrite,
    input  logic                 p2_mem_regWrite,
    input  logic [NREG_BITS-1:0] p3_alu_rd,
    input  logic [NREG_BITS-1:0] p3_mem_rd,
    input  logic                 p3_alu_regWrite,
    input  logic                 p3_mem_regWrite,
    input  logic                 branch_taken,
    input  logic                 dmem_ready,
    input  logic                 p3_memAccess,
    output logic [1:0]           f_alu_reg_rn_sel,
    output logic [1:0]           f_alu_reg_rm_sel,
    output logic [1:0]           f_mem_reg_rn_sel,
    output logic                 f_mem_reg_rd_sel,
    output logic                 p1_pipeline_regWrite,
    output logic                 p2_pipeline_regWrite,
    output logic                 p3_pipeline_regWrite,
    output logic                 p4_pipeline_regWrite,
    output logic                 ID_flush,
    output logic                 EX_flush,
    output logic                 err_mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    input  logic                 clear_cnt,
    output logic [15:0]          stall_load_cnt,
    output logic [15:0]          stall_mem_cnt,
    output logic [15:0]          flush_cnt
`endif
);
    localparam logic [3:0] TO_LAST = 4'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       br_pend;
    logic [1:0] alu_rn_c, alu_rm_c, mem_rn_c;
    logic       lu_arn, lu_arm, lu_mrn;
    logic       rd_p2a, rd_p2m, rd_p3a, rd_p3m;
    logic       mem_rd_c, store_hz, hazard, mem_wait, br;

    vliw_fwd_sel #(.NREG_BITS(NREG_BITS)) u_alu_rn (
        .rs(p1_alu_rn), .use_rs(1'b1),
        .p2_alu_rd(p2_alu_rd), .p2_alu_we(p2_alu_regWrite),
        .p2_mem_rd(p2_mem_rd), .p2_mem_we(p2_mem_regWrite),
        .p3_alu_rd(p3_alu_rd), .p3_alu_we(p3_alu_regWrite),
        .p3_mem_rd(p3_mem_rd), .p3_mem_we(p3_mem_regWrite),
        .sel(alu_rn_c), .p2_load_hit(lu_arn)
    );

    vliw_fwd_sel #(.NREG_BITS(NREG_BITS)) u_alu_rm (
        .rs(p1_alu_rm), .use_rs(p1_alu_useRm),
        .p2_alu_rd(p2_alu_rd), .p2_alu_we(p2_alu_regWrite),
        .p2_mem_rd(p2_mem_rd), .p2_mem_we(p2_mem_regWrite),
        .p3_alu_rd(p3_alu_rd), .p3_alu_we(p3_alu_regWrite),
        .p3_mem_rd(p3_mem_rd), .p3_mem_we(p3_mem_regWrite),
        .sel(alu_rm_c), .p2_load_hit(lu_arm)
    );

    vliw_fwd_sel #(.NREG_BITS(NREG_BITS)) u_mem_rn (
        .rs(p1_mem_rn), .use_rs(1'b1),
        .p2_alu_rd(p2_alu_rd), .p2_alu_we(p2_alu_regWrite),
        .p2_mem_rd(p2_mem_rd), .p2_mem_we(p2_mem_regWrite),
        .p3_alu_rd(p3_alu_rd), .p3_alu_we(p3_alu_regWrite),
        .p3_mem_rd(p3_mem_rd), .p3_mem_we(p3_mem_regWrite),
        .sel(mem_rn_c), .p2_load_hit(lu_mrn)
    );

    assign rd_p2a = p2_alu_regWrite & (p2_alu_rd == p1_mem_rd);
    assign rd_p2m = p2_mem_regWrite & (p2_mem_rd == p1_mem_rd);
    assign rd_p3a = p3_alu_regWrite & (p3_alu_rd == p1_mem_rd);
    assign rd_p3m = p3_mem_regWrite & (p3_mem_rd == p1_mem_rd);

    // Store data can only be bypassed from the p3 ALU result; every other producer must stall.
    assign mem_rd_c = rd_p2a & ~rd_p2m;
    assign store_hz = p1_memWrite & (rd_p2m | (~rd_p2a & (rd_p3a | rd_p3m)));
    assign hazard   = p1_valid & (lu_arn | lu_arm | lu_mrn | store_hz);
    assign mem_wait = p3_memAccess & ~dmem_ready;
    assign br       = branch_taken | br_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= RUN;
            cnt                  <= 4'd0;
            br_pend              <= 1'b0;
            f_alu_reg_rn_sel     <= FWD_REGFILE;
            f_alu_reg_rm_sel     <= FWD_REGFILE;
            f_mem_reg_rn_sel     <= FWD_REGFILE;
            f_mem_reg_rd_sel     <= 1'b0;
            p1_pipeline_regWrite <= 1'b1;
            p2_pipeline_regWrite <= 1'b1;
            p3_pipeline_regWrite <= 1'b1;
            p4_pipeline_regWrite <= 1'b1;
            ID_flush             <= 1'b0;
            EX_flush             <= 1'b0;
            err_mem_timeout      <= 1'b0;
        end else begin
            ID_flush <= 1'b0;
            case (state)
                RUN: begin
                    if (mem_wait) begin
                        state   <= MEM_WAIT;
                        cnt     <= 4'd0;
                        br_pend <= branch_taken;
                        {p1_pipeline_regWrite, p2_pipeline_regWrite,
                         p3_pipeline_regWrite, p4_pipeline_regWrite} <= 4'b0000;
                    end else if (hazard) begin
                        state                <= LOAD_STALL;
                        br_pend              <= branch_taken;
                        p1_pipeline_regWrite <= 1'b0;
                        p2_pipeline_regWrite <= 1'b0;
                        EX_flush             <= 1'b1;
                    end else begin
                        ID_flush <= branch_taken;
                    end
                end
                LOAD_STALL: begin
                    state                <= RUN;
                    p1_pipeline_regWrite <= 1'b1;
                    p2_pipeline_regWrite <= 1'b1;
                    EX_flush             <= 1'b0;
                    ID_flush             <= br;
                    br_pend              <= 1'b0;
                end
                MEM_WAIT: begin
                    if (dmem_ready || cnt == TO_LAST) begin
                        state           <= RUN;
                        cnt             <= 4'd0;
                        ID_flush        <= br;
                        br_pend         <= 1'b0;
                        err_mem_timeout <= err_mem_timeout | ~dmem_ready;
                        {p1_pipeline_regWrite, p2_pipeline_regWrite,
                         p3_pipeline_regWrite, p4_pipeline_regWrite} <= 4'b1111;
                    end else begin
                        cnt     <= cnt + 4'd1;
                        br_pend <= br;
                    end
                end
                default: state <= RUN;
            endcase
            // The bubble entering EX carries no forwarding; selects otherwise follow the p2 enable.
            if (state == RUN && !mem_wait && hazard) begin
                f_alu_reg_rn_sel <= FWD_REGFILE;
                f_alu_reg_rm_sel <= FWD_REGFILE;
                f_mem_reg_rn_sel <= FWD_REGFILE;
                f_mem_reg_rd_sel <= 1'b0;
            end else if (p2_pipeline_regWrite) begin
                f_alu_reg_rn_sel <= alu_rn_c;
                f_alu_reg_rm_sel <= alu_rm_c;
                f_mem_reg_rn_sel <= mem_rn_c;
                f_mem_reg_rd_sel <= mem_rd_c;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear_cnt) begin
            stall_load_cnt <= 16'd0;
            stall_mem_cnt  <= 16'd0;
            flush_cnt      <= 16'd0;
        end else begin
            stall_load_cnt <= sat_inc16(stall_load_cnt, state == LOAD_STALL);
            stall_mem_cnt  <= sat_inc16(stall_mem_cnt, state == MEM_WAIT);
            flush_cnt      <= sat_inc16(flush_cnt, ID_flush);
        end
    end
`endif

endmodule

// File: tb/tb_vliw_hazard_ctrl.sv
// tb_vliw_hazard_ctrl: randomized stimulus, reference model feeding a scoreboard queue, decoupled monitor.
module tb_vliw_hazard_ctrl;

    typedef struct packed {
        logic [1:0] arn;
        logic [1:0] arm;
        logic [1:0] mrn;
        logic       mrd;
    } sel_t;

    typedef struct packed {
        logic [3:0] en;
        logic       idf;
        logic       exf;
        logic       err;
    } ctl_t;

    typedef struct packed {
        sel_t s;
        ctl_t c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] p1_alu_rn = '0, p1_alu_rm = '0, p1_mem_rn = '0, p1_mem_rd = '0;
    logic       p1_alu_useRm = 1'b0, p1_memWrite = 1'b0, p1_valid = 1'b0;
    logic [2:0] p2_alu_rd = '0, p2_mem_rd = '0, p3_alu_rd = '0, p3_mem_rd = '0;
    logic       p2_alu_regWrite = 1'b0, p2_mem_regWrite = 1'b0;
    logic       p3_alu_regWrite = 1'b0, p3_mem_regWrite = 1'b0;
    logic       branch_taken = 1'b0, dmem_ready = 1'b1, p3_memAccess = 1'b0;
    logic [1:0] f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel;
    logic       f_mem_reg_rd_sel;
    logic       p1_pipeline_regWrite, p2_pipeline_regWrite, p3_pipeline_regWrite, p4_pipeline_regWrite;
    logic       ID_flush, EX_flush, err_mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic        clear_cnt = 1'b0;
    logic [15:0] stall_load_cnt, stall_mem_cnt, flush_cnt;
`endif

    vliw_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .p1_alu_rn(p1_alu_rn), .p1_alu_rm(p1_alu_rm), .p1_mem_rn(p1_mem_rn), .p1_mem_rd(p1_mem_rd),
        .p1_alu_useRm(p1_alu_useRm), .p1_memWrite(p1_memWrite), .p1_valid(p1_valid),
        .p2_alu_rd(p2_alu_rd), .p2_mem_rd(p2_mem_rd),
        .p2_alu_regWrite(p2_alu_regWrite), .p2_mem_regWrite(p2_mem_regWrite),
        .p3_alu_rd(p3_alu_rd), .p3_mem_rd(p3_mem_rd),
        .p3_alu_regWrite(p3_alu_regWrite), .p3_mem_regWrite(p3_mem_regWrite),
        .branch_taken(branch_taken), .dmem_ready(dmem_ready), .p3_memAccess(p3_memAccess),
        .f_alu_reg_rn_sel(f_alu_reg_rn_sel), .f_alu_reg_rm_sel(f_alu_reg_rm_sel),
        .f_mem_reg_rn_sel(f_mem_reg_rn_sel), .f_mem_reg_rd_sel(f_mem_reg_rd_sel),
        .p1_pipeline_regWrite(p1_pipeline_regWrite), .p2_pipeline_regWrite(p2_pipeline_regWrite),
        .p3_pipeline_regWrite(p3_pipeline_regWrite), .p4_pipeline_regWrite(p4_pipeline_regWrite),
        .ID_flush(ID_flush), .EX_flush(EX_flush), .err_mem_timeout(err_mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .clear_cnt(clear_cnt), .stall_load_cnt(stall_load_cnt),
        .stall_mem_cnt(stall_mem_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: pipeline situation as plain flags and counts.
    bit   m_stall, m_wait, m_owed, m_err, m_idf;
    int   m_wlen;
    sel_t m_sel;

    function automatic sel_t act_sel();
        return {f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel};
    endfunction

    function automatic ctl_t act_ctl();
        return {p1_pipeline_regWrite, p2_pipeline_regWrite, p3_pipeline_regWrite,
                p4_pipeline_regWrite, ID_flush, EX_flush, err_mem_timeout};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Youngest producer of r: 0 p2 load, 1 p2 ALU, 2 p3 load, 3 p3 ALU, -1 none.
    function automatic int producer(input logic [2:0] r, input bit u);
        if (!u) return -1;
        if (p2_mem_regWrite && p2_mem_rd == r) return 0;
        if (p2_alu_regWrite && p2_alu_rd == r) return 1;
        if (p3_mem_regWrite && p3_mem_rd == r) return 2;
        if (p3_alu_regWrite && p3_alu_rd == r) return 3;
        return -1;
    endfunction

    function automatic logic [1:0] code(input int p);
        return p == 1 ? 2'd1 : p == 2 ? 2'd3 : p == 3 ? 2'd2 : 2'd0;
    endfunction

    task automatic model_reset();
        m_stall = 0; m_wait = 0; m_owed = 0; m_err = 0; m_idf = 0; m_wlen = 0; m_sel = '0;
    endtask

    task automatic model_step();
        int pa, pb, pc, pd;
        bit hz;
        exp_t e;
        pa = producer(p1_alu_rn, 1'b1);
        pb = producer(p1_alu_rm, p1_alu_useRm);
        pc = producer(p1_mem_rn, 1'b1);
        pd = producer(p1_mem_rd, 1'b1);
        hz = p1_valid && (pa == 0 || pb == 0 || pc == 0 ||
                          (p1_memWrite && (pd == 0 || pd == 2 || pd == 3)));
        m_idf = 0;
        if (reset) begin
            model_reset();
        end else if (!m_stall && !m_wait) begin
            if (p3_memAccess && !dmem_ready) begin
                m_wait = 1; m_wlen = 0; m_owed = branch_taken;
                m_sel = {code(pa), code(pb), code(pc), pd == 1};
            end else if (hz) begin
                m_stall = 1; m_owed = branch_taken; m_sel = '0;
            end else begin
                m_idf = branch_taken;
                m_sel = {code(pa), code(pb), code(pc), pd == 1};
            end
        end else if (m_stall) begin
            m_stall = 0; m_idf = m_owed || branch_taken; m_owed = 0;
        end else if (dmem_ready) begin
            m_wait = 0; m_idf = m_owed || branch_taken; m_owed = 0;
        end else begin
            m_wlen++;
            m_owed = m_owed || branch_taken;
            if (m_wlen == 15) begin
                m_err = 1; m_wait = 0; m_idf = m_owed; m_owed = 0;
            end
        end
        e.s = m_sel;
        e.c.en = m_wait ? 4'b0000 : m_stall ? 4'b0011 : 4'b1111;
        e.c.idf = m_idf;
        e.c.exf = m_stall;
        e.c.err = m_err;
        q.push_back(e);
    endtask

    // mode 0: random traffic, 1: dmem stuck busy, 2: reset asserted
    task automatic cycle(input int mode);
        @(negedge clk);
        reset = (mode == 2);
        p1_alu_rn = 3'($urandom_range(0, 3));
        p1_alu_rm = 3'($urandom_range(0, 3));
        p1_mem_rn = 3'($urandom_range(0, 3));
        p1_mem_rd = 3'($urandom_range(0, 3));
        p1_alu_useRm = 1'($urandom_range(0, 1));
        p1_memWrite = 1'($urandom_range(0, 1));
        p1_valid = $urandom_range(0, 7) != 0;
        p2_alu_rd = 3'($urandom_range(0, 3));
        p2_mem_rd = 3'($urandom_range(0, 3));
        p3_alu_rd = 3'($urandom_range(0, 3));
        p3_mem_rd = 3'($urandom_range(0, 3));
        p2_alu_regWrite = 1'($urandom_range(0, 1));
        p2_mem_regWrite = $urandom_range(0, 2) == 0;
        p3_alu_regWrite = 1'($urandom_range(0, 1));
        p3_mem_regWrite = 1'($urandom_range(0, 1));
        branch_taken = $urandom_range(0, 6) == 0;
        p3_memAccess = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        dmem_ready = (mode == 1) ? 1'b0 : $urandom_range(0, 3) != 0;
        model_step();
        if (mode == 2) begin
            #1;
            check("async_reset_sel", 32'(act_sel()), 32'd0);
            check("async_reset_ctl", 32'(act_ctl()), 32'b1111000);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("sel", 32'(act_sel()), 32'(e.s));
                check("ctl", 32'(act_ctl()), 32'(e.c));
            end
        end
    end

    initial begin : stimulus
        model_reset();
        repeat (2) cycle(2);
        repeat (400) cycle(0);
        repeat (20) cycle(1);
        repeat (50) cycle(0);
        repeat (6) cycle(1);
        cycle(2);
        repeat (300) cycle(0);
        repeat (17) cycle(1);
        cycle(2);
        repeat (100) cycle(0);
        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
